// File: rtl/sqrt_unit_ctrl.sv
// sqrt_unit_ctrl: memory-mapped rounded integer square root sequencer (16-bit operand, 8-bit result); ports clk_i, rst_i, start_i, ack_o, busy_o, mem_addr_o, mem_wr_en_o, mem_data_o, mem_data_i
module sqrt_unit_ctrl #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] OPND_ADDR = 16,
  parameter logic [ADDR_W-1:0] RES_ADDR = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              ack_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_en_o,
  output logic [7:0]        mem_data_o,
  input  logic [7:0]        mem_data_i
);
  localparam logic [2:0] IDLE = 3'd0, RD_HI = 3'd1, RD_LO = 3'd2, CALC = 3'd3, ROUND = 3'd4, WR = 3'd5, DONE = 3'd6;
  localparam logic [ADDR_W-1:0] OPND_LO = OPND_ADDR + ADDR_W'(1);
  logic [2:0] state_q, state_d, i_q, i_d;
  logic armed_q, armed_d;
  logic [15:0] x_q, x_d;
  logic [7:0] r_q, r_d;
  logic [10:0] rem_q, rem_d, rem_sh, trial;
  logic ge;
  assign rem_sh = {rem_q[8:0], x_q[{i_q, 1'b1} -: 2]};
  assign trial = {1'b0, r_q, 2'b01};
  assign ge = rem_sh >= trial;
  assign busy_o = state_q != IDLE && state_q != DONE;
  assign ack_o = state_q == DONE;
  assign mem_wr_en_o = state_q == WR;
  assign mem_data_o = state_q == WR ? r_q : 8'h00;
  assign mem_addr_o = state_q == RD_HI ? OPND_ADDR : state_q == RD_LO ? OPND_LO : state_q == WR ? RES_ADDR : '0;
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    x_d = x_q;
    r_d = r_q;
    rem_d = rem_q;
    i_d = i_q;
    case (state_q)
      IDLE: begin
        if (start_i) armed_d = 1'b1;
        else if (armed_q) begin
          armed_d = 1'b0;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        x_d[15:8] = mem_data_i;
        r_d = '0;
        rem_d = '0;
        state_d = RD_LO;
      end
      RD_LO: begin
        x_d[7:0] = mem_data_i;
        i_d = 3'd7;
        state_d = CALC;
      end
      CALC: begin
        rem_d = ge ? rem_sh - trial : rem_sh;
        r_d = {r_q[6:0], ge};
        i_d = i_q - 3'd1;
        state_d = i_q == 3'd0 ? ROUND : CALC;
      end
      ROUND: begin
        // remainder above the root means the fractional part is at least one half
        r_d = rem_q > {3'b000, r_q} && r_q != 8'hFF ? r_q + 8'd1 : r_q;
        state_d = WR;
      end
      WR: state_d = DONE;
      DONE: begin
        if (start_i) begin
          armed_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      x_q <= '0;
      r_q <= '0;
      rem_q <= '0;
      i_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      x_q <= x_d;
      r_q <= r_d;
      rem_q <= rem_d;
      i_q <= i_d;
    end
  end
endmodule

// File: tb/tb_sqrt_unit_ctrl.sv
// tb_sqrt_unit_ctrl: table-driven scoreboard bench for sqrt_unit_ctrl
module tb_sqrt_unit_ctrl;
  typedef struct {
    logic [15:0] x;
    logic [7:0] e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic ack, busy, wr_en;
  logic [7:0] addr, dout, din;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int n_checks = 0, n_fail = 0, writes = 0;
  vec_t vecs [9];
  sqrt_unit_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ack_o(ack), .busy_o(busy),
    .mem_addr_o(addr), .mem_wr_en_o(wr_en), .mem_data_o(dout), .mem_data_i(din)
  );
  always #5 clk = ~clk;
  assign din = mem[addr];
  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(posedge clk) begin
    if (wr_en) begin
      logic [7:0] e;
      mem[addr] = dout;
      writes++;
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_data", dout, e);
        check("wr_addr", addr, 18);
      end
    end
  end
  task automatic launch(input logic [15:0] x, output bit was_done);
    mem[16] = x[15:8];
    mem[17] = x[7:0];
    mem[18] = 8'hAA;
    was_done = ack;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    if (was_done) check("ack_clear", ack, 0);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(negedge clk) check("busy_run", busy, 1);
  endtask
  task automatic run_op(input logic [15:0] x, input logic [7:0] e, input bit pulse_mid);
    int cyc, w0;
    bit wd;
    exp_q.push_back(e);
    w0 = writes;
    launch(x, wd);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (pulse_mid) start = cyc == 4;
    end while (!ack && cyc < 40);
    check("latency", cyc, 12);
    check("result", mem[18], e);
    check("one_write", writes - w0, 1);
  endtask
  initial begin
    int w0;
    bit wd;
    vecs[0] = '{16'd81, 8'h09};
    vecs[1] = '{16'd90, 8'h09};
    vecs[2] = '{16'd91, 8'h0A};
    vecs[3] = '{16'd3, 8'h02};
    vecs[4] = '{16'd0, 8'h00};
    vecs[5] = '{16'd65025, 8'hFF};
    vecs[6] = '{16'd65535, 8'hFF};
    vecs[7] = '{16'd81, 8'h09};
    vecs[8] = '{16'd256, 8'h10};
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", wr_en, 0);
    check("rst_addr", addr, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) run_op(vecs[k].x, vecs[k].e, 1'b0);
    run_op(16'd81, 8'h09, 1'b1);
    w0 = writes;
    repeat (5) @(negedge clk);
    check("no_relaunch_writes", writes - w0, 0);
    check("still_done", ack, 1);
    launch(16'd81, wd);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr", wr_en, 0);
    check("mid_rst_addr", addr, 0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_mem", mem[18], 8'hAA);
    check("mid_rst_writes", writes - w0, 0);
    check("mid_rst_idle", busy, 0);
    run_op(16'd81, 8'h09, 1'b0);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
